// File: rtl/myproject_sdiv_23s_10ns_16_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient bit per clock.
// Quotient is saturated to dout_WIDTH; the remainder carries the dividend's sign.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring-division step per edge, count 0..din0_WIDTH-1
// DONE  | result held, out_valid high until out_ready
module myproject_sdiv_23s_10ns_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 23,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);
  localparam logic signed [din0_WIDTH:0] QMAX = (din0_WIDTH+1)'((2 ** (dout_WIDTH - 1)) - 1);
  localparam logic signed [din0_WIDTH:0] QMIN = -(din0_WIDTH+1)'(2 ** (dout_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_count;
  logic [din0_WIDTH-1:0]   r_dq;
  logic [din1_WIDTH-1:0]   r_part;
  logic [din1_WIDTH-1:0]   r_divisor;
  logic                    r_sign;
  logic                    r_dz;
  logic [dout_WIDTH-1:0]   r_quot;
  logic [din1_WIDTH:0]     r_rem;
  logic                    r_ovf;

  logic [din0_WIDTH:0]     w_din0_neg;
  logic [din0_WIDTH-1:0]   w_din0_abs;
  logic [din1_WIDTH:0]     w_r_shift;
  logic [din1_WIDTH:0]     w_diff;
  logic                    w_ge;
  logic [din1_WIDTH-1:0]   w_r_next;
  logic [din0_WIDTH-1:0]   w_q_next;
  logic signed [din0_WIDTH:0] w_q_signed;
  logic [din1_WIDTH:0]     w_rem_signed;
  logic                    w_unused;

  // Wide negation so that the most negative dividend maps to its true magnitude.
  assign w_din0_neg = '0 - {din0[din0_WIDTH-1], din0};
  assign w_din0_abs = din0[din0_WIDTH-1] ? w_din0_neg[din0_WIDTH-1:0] : din0;

  assign w_r_shift = {r_part, r_dq[din0_WIDTH-1]};
  assign w_diff    = w_r_shift - {1'b0, r_divisor};
  assign w_ge      = (w_r_shift >= {1'b0, r_divisor});
  assign w_r_next  = w_ge ? w_diff[din1_WIDTH-1:0] : w_r_shift[din1_WIDTH-1:0];
  assign w_q_next  = {r_dq[din0_WIDTH-2:0], w_ge};

  assign w_q_signed   = r_sign ? -$signed({1'b0, w_q_next}) : $signed({1'b0, w_q_next});
  assign w_rem_signed = r_sign ? ('0 - {1'b0, w_r_next}) : {1'b0, w_r_next};

  assign w_unused = w_diff[din1_WIDTH] ^ (ID == 0);

  assign in_ready  = (r_state == IDLE) && ap_rst_n;
  assign out_valid = (r_state == DONE);
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)         w_state_nxt = CALC;
      CALC:    if (r_count == LAST)  w_state_nxt = DONE;
      DONE:    if (out_ready)        w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_count   <= '0;
      r_dq      <= '0;
      r_part    <= '0;
      r_divisor <= '0;
      r_sign    <= 1'b0;
      r_dz      <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_dq      <= w_din0_abs;
          r_divisor <= din1;
          r_sign    <= din0[din0_WIDTH-1];
          r_dz      <= (din1 == '0);
          r_part    <= '0;
          r_count   <= '0;
        end
        CALC: begin
          r_dq    <= w_q_next;
          r_part  <= w_r_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            // Divide-by-zero still runs the full iteration; only the result is overridden.
            if (r_dz) begin
              r_quot <= r_sign ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
              r_rem  <= '0;
              r_ovf  <= 1'b0;
            end else begin
              r_rem <= w_rem_signed;
              if (w_q_signed > QMAX) begin
                r_quot <= {1'b0, {(dout_WIDTH-1){1'b1}}};
                r_ovf  <= 1'b1;
              end else if (w_q_signed < QMIN) begin
                r_quot <= {1'b1, {(dout_WIDTH-1){1'b0}}};
                r_ovf  <= 1'b1;
              end else begin
                r_quot <= w_q_signed[dout_WIDTH-1:0];
                r_ovf  <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/myproject_sdiv_23s_10ns_16_seq.md
# myproject_sdiv_23s_10ns_16_seq

Sequential signed-by-unsigned integer divider: the inverse of the datapath's 16s×10ns→23 product multiplier. It takes a 23-bit signed dividend and a 10-bit unsigned divisor, and returns a 16-bit signed saturated quotient and an 11-bit signed remainder. It computes one quotient bit per cycle and uses a valid/ready handshake on both sides. It serves the dense-layer rescaling path, where accumulated products are normalised back to the 16-bit activation format.

## Interface
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 23, dividend width (signed); also the iteration count.
- din1_WIDTH, 10, divisor width (unsigned).
- dout_WIDTH, 16, quotient width (signed, saturated).
---
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block idle and able to accept operands.
- din0  in  din0_WIDTH  dividend, two's complement.
- din1  in  din1_WIDTH  divisor, unsigned.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- quot  out  dout_WIDTH  quotient, truncated toward zero, saturated.
- rem  out  din1_WIDTH+1  remainder, signed; takes the dividend's sign.
- ovf  out  1  quotient was saturated.
- dz  out  1  divisor was zero.

## Operation
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE transition: on in_valid && in_ready, the block
  - registers |din0| (23-bit unsigned; -2^22 maps to 2^22), din1, sign(din0) and dz = (din1==0);
  - clears the partial remainder and sets count=0;
  - moves to CALC.
- CALC, restoring division, MSB first, one bit per edge:
  - r' = {r, next dividend bit};
  - if r' ≥ divisor, subtract the divisor and shift in 1; else shift in 0;
  - count increments each edge.
- On the CALC edge with count == din0_WIDTH-1 (the final bit), the block registers the outputs and moves to DONE:
  - Unsaturated quotient q = sign ? -Q : Q. Remainder = sign ? -R : R.
  - If q > 32767, quot = 0x7FFF and ovf=1. If q < -32768, quot = 0x8000 and ovf=1. Otherwise quot = q and ovf=0.
  - rem is always the true truncated remainder, even when quot saturates.
  - If dz=1: quot = 0x7FFF when the dividend ≥ 0, 0x8000 when negative; rem=0; ovf=0. The iteration still runs the full count, so latency is uniform.
- DONE transition: outputs are held stable while out_ready=0. On out_ready=1 the block returns to IDLE. quot, rem, ovf and dz keep their last values but are meaningful only while out_valid=1.
- in_valid is ignored outside IDLE. The operands need to be valid only on the accepting edge.
- Arithmetic: the partial remainder is din1_WIDTH+1 bits wide. Negation uses 24-bit intermediates, so 2^22 is never truncated.

## Timing
- Reset (ap_rst_n low, effective immediately with no clock):
  - state=IDLE, count=0;
  - quot=0, rem=0, ovf=0, dz=0, out_valid=0;
  - in_ready=0 while ap_rst_n is low, and 1 from the first cycle after deassertion.
- Latency: an operand accepted at edge E0 produces out_valid=1 after edge E0+23. That is 1 capture edge + 22 further CALC edges (23 CALC edges in total, E1..E23, of which the last registers the outputs).
- Throughput: with out_ready held high, the result handshakes at E24 and in_ready=1 after E24. The next accept is at E25, so there is one operation per 25 cycles. Requests are never overlapped.
- Reset asserted in CALC or DONE aborts the operation and discards the result. There is no out_valid pulse for the aborted operation.
- in_valid and out_ready have no combinational path to each other. in_ready and out_valid are decoded from registered state only.

## Test plan
- din0=1000, din1=7 → quot=142, rem=6, ovf=0, dz=0; out_valid rises exactly 23 edges after acceptance.
- din0=-1000 (0x7FFC18), din1=7 → quot=0xFF72 (-142), rem=0x7FA (-6).
- din0=0x3FFFFF, din1=1 → quot=0x7FFF, ovf=1. din0=0x400000 (-2^22), din1=1 → quot=0x8000, ovf=1, rem=0. din0=-32768, din1=1 → quot=0x8000, ovf=0.
- din0=-5, din1=0 → dz=1, quot=0x8000, rem=0, same latency. din0=5, din1=0 → quot=0x7FFF.
- Backpressure: out_ready=0 for 10 cycles after out_valid while in_valid=1 with new operands → outputs unchanged, in_ready=0, the second operand is not taken until the cycle after the result handshake.
- ap_rst_n pulsed low 1 ns mid-CALC (count=10) → all outputs 0 immediately. A fresh 100/3 issued after reset → quot=33, rem=1 with nominal latency.
